// File: rtl/stack_prog_loader.sv
// Byte-stream program loader for the stack-machine core: checks framing, opcodes and
// checksum, writes 12-bit words into instruction memory and releases the core on success.
module stack_prog_loader #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned MAX_OPCODE = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [11:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam int unsigned  REM_W   = ADDR_W + 1;
    localparam logic [REM_W-1:0] REM_FULL = REM_W'(2 ** ADDR_W);
    localparam logic [3:0]   MAX_OP  = 4'(MAX_OPCODE);
    localparam logic [1:0]   ERR_HI  = 2'b01;
    localparam logic [1:0]   ERR_OP  = 2'b10;
    localparam logic [1:0]   ERR_CHK = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_LO, S_HI, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t            state;
    logic [REM_W-1:0]  remaining;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        lo_byte;
    logic [7:0]        acc;
    logic              accept;

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            remaining  <= '0;
            addr       <= '0;
            lo_byte    <= '0;
            acc        <= '0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst_n <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_COUNT;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        core_rst_n <= 1'b0;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        err_code   <= '0;
                        acc        <= '0;
                        addr       <= '0;
                        remaining  <= '0;
                    end
                end
                S_COUNT: begin
                    if (accept) begin
                        remaining <= (in_data == 8'd0) ? REM_FULL : REM_W'(in_data);
                        acc       <= acc ^ in_data;
                        state     <= S_LO;
                    end
                end
                S_LO: begin
                    if (accept) begin
                        lo_byte <= in_data;
                        acc     <= acc ^ in_data;
                        state   <= S_HI;
                    end
                end
                S_HI: begin
                    if (accept) begin
                        // Rejected words leave imem_we low and drop straight into ERR.
                        if (in_data[7:4] != 4'd0) begin
                            state    <= S_ERR;
                            err_code <= ERR_HI;
                            error    <= 1'b1;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                        end else if (lo_byte[3:0] > MAX_OP) begin
                            state    <= S_ERR;
                            err_code <= ERR_OP;
                            error    <= 1'b1;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
                            imem_we    <= 1'b1;
                            imem_addr  <= addr;
                            imem_wdata <= {in_data[3:0], lo_byte};
                            addr       <= addr + ADDR_W'(1);
                            remaining  <= remaining - REM_W'(1);
                            acc        <= acc ^ in_data;
                            state      <= (remaining == REM_W'(1)) ? S_CHK : S_LO;
                        end
                    end
                end
                S_CHK: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (in_data == acc) begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            core_rst_n <= 1'b1;
                        end else begin
                            state    <= S_ERR;
                            err_code <= ERR_CHK;
                            error    <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_prog_loader.sv
// Randomized frame-level bench for stack_prog_loader with a frame-parsing reference model.
module tb_stack_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, imem_we, core_rst_n, busy, done, error;
    logic [7:0]  imem_addr;
    logic [11:0] imem_wdata;
    logic [1:0]  err_code;

    stack_prog_loader #(.ADDR_W(8), .MAX_OPCODE(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n), .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    logic [7:0]  frame[$];
    logic [11:0] m_words[$];
    int          m_code;
    int          m_used;
    logic [19:0] exp_q[$];
    logic [11:0] mem[256];
    int          wcount[256];
    int          nwrites;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: parse the frame byte by byte from the framing rules.
    task automatic run_model();
        int n, idx;
        logic [7:0] acc, lo, hi;
        m_words.delete();
        m_code = 0;
        n = (frame[0] == 8'd0) ? 256 : int'(frame[0]);
        acc = frame[0];
        idx = 1;
        for (int i = 0; i < n; i++) begin
            lo = frame[idx];
            hi = frame[idx + 1];
            if (hi[7:4] != 4'd0) begin m_code = 1; m_used = idx + 2; return; end
            if (lo[3:0] > 4'd10) begin m_code = 2; m_used = idx + 2; return; end
            m_words.push_back({hi[3:0], lo});
            acc = acc ^ lo ^ hi;
            idx += 2;
        end
        m_code = (frame[idx] == acc) ? 0 : 3;
        m_used = idx + 1;
    endtask

    task automatic build_frame(input int n, input int err);
        logic [31:0] r;
        logic [7:0]  acc, lo, hi, c;
        int bad;
        frame.delete();
        c = 8'(n);
        frame.push_back(c);
        acc = c;
        bad = int'($urandom_range(0, n - 1));
        for (int i = 0; i < n; i++) begin
            r = $urandom;
            lo = {r[7:4], 4'($urandom_range(0, 10))};
            hi = {4'h0, r[11:8]};
            if (err == 1 && i == bad) hi[7:4] = 4'($urandom_range(1, 15));
            if (err == 2 && i == bad) lo[3:0] = 4'($urandom_range(11, 15));
            frame.push_back(lo);
            frame.push_back(hi);
            acc = acc ^ lo ^ hi;
        end
        if (err == 3) acc = acc ^ 8'($urandom_range(1, 255));
        frame.push_back(acc);
    endtask

    // Per-cycle checks and write scoreboard.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy_eq_ready", {31'b0, busy}, {31'b0, in_ready});
            chk("core_rst_eq_done", {31'b0, core_rst_n}, {31'b0, done});
            chk("no_we_in_err", {31'b0, imem_we & error}, 32'd0);
            if (imem_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {20'b0, imem_addr, imem_wdata}, 32'hFFFF_FFFF);
                end else begin
                    chk("write", {12'b0, imem_addr, imem_wdata}, {12'b0, exp_q.pop_front()});
                end
                mem[imem_addr] = imem_wdata;
                wcount[imem_addr]++;
                nwrites++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gapmax);
        int g, to;
        g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
        repeat (g) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        to = 0;
        while (!in_ready && to < 50) begin
            @(negedge clk);
            to++;
        end
        if (to >= 50) chk("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic arm();
        run_model();
        exp_q.delete();
        foreach (m_words[i]) exp_q.push_back({8'(i), m_words[i]});
        for (int a = 0; a < 256; a++) wcount[a] = 0;
        nwrites = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ready_after_start", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic do_load(input int gapmax);
        arm();
        for (int i = 0; i < m_used; i++) send_byte(frame[i], gapmax);
        repeat (3) @(negedge clk);
        chk("done", {31'b0, done}, (m_code == 0) ? 32'd1 : 32'd0);
        chk("error", {31'b0, error}, (m_code != 0) ? 32'd1 : 32'd0);
        chk("err_code", {30'b0, err_code}, 32'(m_code));
        chk("core_rst_n", {31'b0, core_rst_n}, (m_code == 0) ? 32'd1 : 32'd0);
        chk("ready_idle", {31'b0, in_ready}, 32'd0);
        chk("write_count", 32'(nwrites), 32'(m_words.size()));
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
        chk({tag, "_imem_we"}, {31'b0, imem_we}, 32'd0);
        chk({tag, "_imem_addr"}, {24'b0, imem_addr}, 32'd0);
        chk({tag, "_imem_wdata"}, {20'b0, imem_wdata}, 32'd0);
        chk({tag, "_core_rst_n"}, {31'b0, core_rst_n}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_error"}, {31'b0, error}, 32'd0);
        chk({tag, "_err_code"}, {30'b0, err_code}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_cnt;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        nwrites = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Reference frame 02 10 00 25 01 36, model pinned by hand-computed values.
        frame = '{8'h02, 8'h10, 8'h00, 8'h25, 8'h01, 8'h36};
        run_model();
        chk("model_a_code", 32'(m_code), 32'd0);
        chk("model_a_count", 32'(m_words.size()), 32'd2);
        chk("model_a_w0", {20'b0, m_words[0]}, 32'h010);
        chk("model_a_w1", {20'b0, m_words[1]}, 32'h125);
        do_load(0);
        chk("imem0", {20'b0, mem[0]}, 32'h010);
        chk("imem1", {20'b0, mem[1]}, 32'h125);
        chk("done_literal", {31'b0, done}, 32'd1);

        do_load(3);

        frame = '{8'h02, 8'h10, 8'h00, 8'h25, 8'h10, 8'h00};
        do_load(1);
        chk("bad_hi_code", {30'b0, err_code}, 32'd1);

        frame = '{8'h02, 8'h10, 8'h00, 8'h0B, 8'h01, 8'h00};
        run_model();
        chk("model_op_code", 32'(m_code), 32'd2);
        chk("model_op_count", 32'(m_words.size()), 32'd1);
        do_load(0);
        chk("bad_op_keep_w0", {20'b0, mem[0]}, 32'h010);

        frame = '{8'h02, 8'h10, 8'h00, 8'h25, 8'h01, 8'h00};
        do_load(2);
        chk("bad_chk_code", {30'b0, err_code}, 32'd3);
        chk("bad_chk_done", {31'b0, done}, 32'd0);

        frame = '{8'h02, 8'h10, 8'h00, 8'h25, 8'h01, 8'h36};
        do_load(0);
        chk("recover_error", {31'b0, error}, 32'd0);

        for (int k = 0; k < 20; k++) begin
            build_frame(int'($urandom_range(1, 8)), int'($urandom_range(0, 3)));
            do_load(3);
        end

        // Full 256-word load: every address written exactly once.
        build_frame(256, 0);
        do_load(0);
        bad_cnt = 0;
        for (int a = 0; a < 256; a++) if (wcount[a] != 1) bad_cnt++;
        chk("full_addr_once", 32'(bad_cnt), 32'd0);

        // 256-word load interrupted by reset after word 100; start pulsed while busy.
        build_frame(256, 0);
        arm();
        for (int i = 0; i < 201; i++) begin
            send_byte(frame[i], 0);
            if (i == 50) begin
                chk("busy_mid", {31'b0, busy}, 32'd1);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_writes", 32'(nwrites), 32'd100);
        chk("rst_pending", 32'(exp_q.size()), 32'd156);
        exp_q.delete();
        check_reset_outputs("midreset");
        repeat (5) @(negedge clk);
        chk("rst_no_more", 32'(nwrites), 32'd100);

        build_frame(4, 0);
        do_load(2);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
